// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with a one-word holding slot per channel.
// Routing is by sel, or by an internal round-robin pointer when rr_mode is set.
module demux1to4_stream #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    sel,
  input  logic          rr_mode,
  output logic [DW-1:0] out_data0,
  output logic [DW-1:0] out_data1,
  output logic [DW-1:0] out_data2,
  output logic [DW-1:0] out_data3,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [1:0]    rr_ptr,
  output logic [CW-1:0] xfer_cnt
);

  logic [1:0]    tgt;
  logic          acc;
  logic [3:0]    valid_q, valid_d;
  logic [DW-1:0] data_q [4];
  logic [DW-1:0] data_d [4];
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign tgt      = rr_mode ? ptr_q : sel;
  // A full slot can still take a word in the cycle its consumer drains it.
  assign in_ready = ~valid_q[tgt] | out_ready[tgt];
  assign acc      = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q & ~out_ready;
    data_d  = data_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (acc) begin
      valid_d[tgt] = 1'b1;
      data_d[tgt]  = in_data;
      cnt_d        = cnt_q + CW'(1);
      if (rr_mode) begin
        ptr_d = ptr_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign out_valid = valid_q;
  assign rr_ptr    = ptr_q;
  assign xfer_cnt  = cnt_q;

endmodule
